// File: rtl/router_fifo_pkg.sv
// Shared types and width helpers for the router virtual-channel FIFO.
// Included by the lane and the top via import router_fifo_pkg::*.
package router_fifo_pkg;

    function automatic int vc_w(input int num_vc);
        return (num_vc > 1) ? $clog2(num_vc) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_full;
        logic overflow;
        logic underflow;
    } vc_status_t;

    localparam string MSG_PUSH_VC_RANGE = "router_vc_fifo: push_vc >= NUM_VC, request ignored";
    localparam string MSG_POP_VC_RANGE  = "router_vc_fifo: pop_vc >= NUM_VC, request ignored";

endpackage

// File: rtl/router_vc_lane.sv
// One virtual-channel queue: storage, wrap-explicit pointers, occupancy count
// and sticky overflow/underflow flags. push_en/pop_en arrive already decoded.
module router_vc_lane
    import router_fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 3,
    parameter  int AF_MARGIN  = 1,
    localparam int CNT_W      = cnt_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_en,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop_en,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [CNT_W-1:0]      count,
    output vc_status_t            status
);

    localparam int                PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  AF_CNT   = CNT_W'(DEPTH - AF_MARGIN);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  is_empty;
    logic                  is_full;
    logic                  pop_ok;
    logic                  push_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign is_empty = (count == '0);
    assign is_full  = (count == FULL_CNT);
    assign pop_ok   = pop_en && !is_empty;
    // A full lane still takes a push when the same cycle frees a slot.
    assign push_ok  = push_en && (!is_full || pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (clr_err) begin
                overflow_q  <= 1'b0;
                underflow_q <= 1'b0;
            end else begin
                if (push_en && !push_ok) overflow_q  <= 1'b1;
                if (pop_en && !pop_ok)   underflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

    assign status = '{
        empty:       is_empty,
        full:        is_full,
        almost_full: (count >= AF_CNT),
        overflow:    overflow_q,
        underflow:   underflow_q
    };

endmodule

// File: rtl/router_vc_fifo.sv
// Multi-VC input FIFO: decodes push/pop VC selects into one-hot lane enables,
// instantiates one router_vc_lane per VC and muxes the show-ahead head by pop_vc.
module router_vc_fifo
    import router_fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 3,
    parameter  int NUM_VC     = 4,
    parameter  int AF_MARGIN  = 1,
    localparam int VC_W       = vc_w(NUM_VC),
    localparam int CNT_W      = cnt_w(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic [VC_W-1:0]         push_vc,
    input  logic [DATA_WIDTH-1:0]   push_data,
    input  logic                    pop,
    input  logic [VC_W-1:0]         pop_vc,
    output logic [DATA_WIDTH-1:0]   pop_data,
    output logic                    pop_valid,
    output logic [NUM_VC-1:0]       empty,
    output logic [NUM_VC-1:0]       full,
    output logic [NUM_VC-1:0]       almost_full,
    output logic [NUM_VC*CNT_W-1:0] count,
    output logic [NUM_VC-1:0]       overflow,
    output logic [NUM_VC-1:0]       underflow,
    input  logic                    clr_err
);

    logic [NUM_VC-1:0]     push_en;
    logic [NUM_VC-1:0]     pop_sel;
    logic [NUM_VC-1:0]     pop_en;
    logic [DATA_WIDTH-1:0] lane_data   [NUM_VC];
    logic [DATA_WIDTH-1:0] lane_masked [NUM_VC];
    vc_status_t            lane_status [NUM_VC];

    for (genvar g = 0; g < NUM_VC; g++) begin : g_lane
        // Out-of-range selects match no lane, so they are dropped without flags.
        assign push_en[g] = push && (push_vc == VC_W'(g));
        assign pop_sel[g] = (pop_vc == VC_W'(g));
        assign pop_en[g]  = pop && pop_sel[g];

        router_vc_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH),
            .AF_MARGIN  (AF_MARGIN)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .push_en   (push_en[g]),
            .push_data (push_data),
            .pop_en    (pop_en[g]),
            .clr_err   (clr_err),
            .head_data (lane_data[g]),
            .count     (count[g*CNT_W +: CNT_W]),
            .status    (lane_status[g])
        );

        assign empty[g]       = lane_status[g].empty;
        assign full[g]        = lane_status[g].full;
        assign almost_full[g] = lane_status[g].almost_full;
        assign overflow[g]    = lane_status[g].overflow;
        assign underflow[g]   = lane_status[g].underflow;
        assign lane_masked[g] = pop_sel[g] ? lane_data[g] : '0;
    end

    always_comb begin
        pop_data = '0;
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            pop_data = pop_data | lane_masked[v];
        end
    end

    assign pop_valid = |(pop_sel & ~empty);

`ifdef SIM_ONLY
    a_push_vc_range: assert property (@(posedge clk) disable iff (!rst_n) push |-> (|push_en))
        else $error("%s", MSG_PUSH_VC_RANGE);
    a_pop_vc_range: assert property (@(posedge clk) disable iff (!rst_n) pop |-> (|pop_sel))
        else $error("%s", MSG_POP_VC_RANGE);
`endif

endmodule

// File: tb/tb_router_vc_fifo.sv
// Directed self-checking bench for router_vc_fifo (DATA_WIDTH=8, DEPTH=3,
// NUM_VC=4, AF_MARGIN=1) with hand-computed expected values.
module tb_router_vc_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 3;
    localparam int NVC   = 4;
    localparam int AFM   = 1;
    localparam int VCW   = 2;
    localparam int CW    = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              push;
    logic [VCW-1:0]    push_vc;
    logic [DW-1:0]     push_data;
    logic              pop;
    logic [VCW-1:0]    pop_vc;
    logic [DW-1:0]     pop_data;
    logic              pop_valid;
    logic [NVC-1:0]    empty;
    logic [NVC-1:0]    full;
    logic [NVC-1:0]    almost_full;
    logic [NVC*CW-1:0] count;
    logic [NVC-1:0]    overflow;
    logic [NVC-1:0]    underflow;
    logic              clr_err;

    int checks   = 0;
    int failures = 0;

    router_vc_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .NUM_VC     (NVC),
        .AF_MARGIN  (AFM)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .push_vc     (push_vc),
        .push_data   (push_data),
        .pop         (pop),
        .pop_vc      (pop_vc),
        .pop_data    (pop_data),
        .pop_valid   (pop_valid),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .clr_err     (clr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [CW-1:0] cnt(input int v);
        return count[v*CW +: CW];
    endfunction

    // Apply one cycle of requests, clock it, and return #1 after the edge.
    task automatic cycle(input logic ps, input logic [VCW-1:0] pvc, input logic [DW-1:0] pd,
                         input logic pp, input logic [VCW-1:0] ovc, input logic clr);
        push = ps; push_vc = pvc; push_data = pd;
        pop = pp; pop_vc = ovc; clr_err = clr;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    endtask

    task automatic push_only(input logic [VCW-1:0] vc, input logic [DW-1:0] d);
        cycle(1'b1, vc, d, 1'b0, '0, 1'b0);
    endtask

    task automatic pop_only(input logic [VCW-1:0] vc);
        cycle(1'b0, '0, '0, 1'b1, vc, 1'b0);
    endtask

    task automatic peek(input string tag, input logic [VCW-1:0] vc, input logic [DW-1:0] exp);
        pop_vc = vc;
        #1;
        check(tag, pop_data, exp);
        check({tag, "_valid"}, pop_valid, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        push = 1'b0; push_vc = '0; push_data = '0;
        pop = 1'b0; pop_vc = '0; clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b0, '0, '0, 1'b0, '0, 1'b0);
        cycle(1'b0, '0, '0, 1'b0, '0, 1'b0);

        // Reset state
        check("rst_empty", empty, 4'b1111);
        check("rst_full", full, 4'b0000);
        check("rst_af", almost_full, 4'b0000);
        check("rst_count", count, 8'h00);
        check("rst_ovf", overflow, 4'b0000);
        check("rst_udf", underflow, 4'b0000);
        check("rst_pop_valid", pop_valid, 0);

        // Fill VC2 to full, then overflow
        push_only(2'd2, 8'h11);
        check("vc2_cnt1", cnt(2), 1);
        check("vc2_af1", almost_full, 4'b0000);
        push_only(2'd2, 8'h22);
        check("vc2_cnt2", cnt(2), 2);
        check("vc2_af2", almost_full, 4'b0100);
        check("vc2_full2", full, 4'b0000);
        push_only(2'd2, 8'h33);
        check("vc2_cnt3", cnt(2), 3);
        check("vc2_full3", full, 4'b0100);
        push_only(2'd2, 8'h44);
        check("vc2_ovf", overflow, 4'b0100);
        check("vc2_cnt_ovf", cnt(2), 3);
        peek("vc2_head0", 2'd2, 8'h11);
        pop_only(2'd2);
        peek("vc2_head1", 2'd2, 8'h22);
        pop_only(2'd2);
        peek("vc2_head2", 2'd2, 8'h33);
        pop_only(2'd2);
        check("vc2_drained_cnt", cnt(2), 0);
        check("vc2_drained_empty", empty, 4'b1111);
        pop_vc = 2'd2;
        #1;
        check("vc2_drained_valid", pop_valid, 0);

        // Pointer wrap on VC1
        for (int i = 0; i < 10; i++) begin
            push_only(2'd1, DW'(i));
            check("wrap_cnt_push", cnt(1), 1);
            peek("wrap_data", 2'd1, DW'(i));
            pop_only(2'd1);
            check("wrap_cnt_pop", cnt(1), 0);
        end

        // VC0 full: simultaneous push+pop on VC0, then push VC3 + pop VC0
        push_only(2'd0, 8'hA0);
        push_only(2'd0, 8'hA1);
        push_only(2'd0, 8'hA2);
        check("vc0_full", full, 4'b0001);
        peek("vc0_head_a0", 2'd0, 8'hA0);
        cycle(1'b1, 2'd0, 8'h55, 1'b1, 2'd0, 1'b0);
        check("vc0_pp_cnt", cnt(0), 3);
        check("vc0_pp_full", full, 4'b0001);
        check("vc0_pp_ovf", overflow, 4'b0100);
        peek("vc0_head_a1", 2'd0, 8'hA1);
        cycle(1'b1, 2'd3, 8'h66, 1'b1, 2'd0, 1'b0);
        check("indep_cnt0", cnt(0), 2);
        check("indep_cnt3", cnt(3), 1);
        peek("indep_vc3_head", 2'd3, 8'h66);
        peek("indep_vc0_head", 2'd0, 8'hA2);
        pop_only(2'd0);
        peek("vc0_head_55", 2'd0, 8'h55);
        pop_only(2'd0);
        pop_only(2'd3);
        check("all_empty", empty, 4'b1111);

        // Same-VC push+pop on empty VC1: no bypass, underflow flagged
        cycle(1'b1, 2'd1, 8'hAA, 1'b1, 2'd1, 1'b0);
        check("nobyp_cnt", cnt(1), 1);
        check("nobyp_udf", underflow, 4'b0010);
        peek("nobyp_data", 2'd1, 8'hAA);
        cycle(1'b0, '0, '0, 1'b0, '0, 1'b1);
        check("clr_udf", underflow, 4'b0000);
        check("clr_ovf", overflow, 4'b0000);
        pop_only(2'd3);
        check("udf_vc3", underflow, 4'b1000);
        cycle(1'b0, '0, '0, 1'b1, 2'd2, 1'b1);
        check("clr_priority", underflow, 4'b0000);
        check("nobyp_cnt_kept", cnt(1), 1);

        // Async reset mid-operation
        push_only(2'd0, 8'h01);
        push_only(2'd0, 8'h02);
        push_only(2'd2, 8'h03);
        check("pre_rst_count", count, 8'h16);
        rst_n = 1'b0;
        #1;
        check("mid_rst_count", count, 8'h00);
        check("mid_rst_empty", empty, 4'b1111);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("post_rst_empty", empty, 4'b1111);
        check("post_rst_count", count, 8'h00);
        push_only(2'd0, 8'h77);
        peek("post_rst_data", 2'd0, 8'h77);
        check("post_rst_cnt0", cnt(0), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/router_vc_fifo.md
# router_vc_fifo

Multi-channel FIFO for router input ports: NUM_VC independent virtual-channel queues of arbitrary (non-power-of-two) depth, each with its own occupancy counter, full/almost-full/empty status and sticky error flags. It sits between the port deserialiser and the VC arbiter. It is the parametrised successor of the single-queue router FIFO. New over that block: per-VC occupancy counts, an almost-full threshold for credit return, and detection of illegal push/pop instead of pointer corruption.

## Interface
- DATA_WIDTH, default 8: payload bits per entry.
- DEPTH, default 3: entries per VC; any value ≥ 2.
- NUM_VC, default 4: number of virtual channels; ≥ 1.
- AF_MARGIN, default 1: almost_full asserts when count ≥ DEPTH − AF_MARGIN; range 0..DEPTH−1.
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- push  in  1  write request.
- push_vc  in  VC_W  target VC of the write (VC_W = max(1,$clog2(NUM_VC))).
- push_data  in  DATA_WIDTH  write payload.
- pop  in  1  read request.
- pop_vc  in  VC_W  VC to read.
- pop_data  out  DATA_WIDTH  head entry of pop_vc (show-ahead, combinational from storage).
- pop_valid  out  1  pop_vc is non-empty.
- empty  out  NUM_VC  per-VC empty.
- full  out  NUM_VC  per-VC full.
- almost_full  out  NUM_VC  per-VC threshold flag.
- count  out  NUM_VC×CNT_W  per-VC occupancy, CNT_W = $clog2(DEPTH+1).
- overflow  out  NUM_VC  sticky: push to a full VC that was dropped.
- underflow  out  NUM_VC  sticky: pop of an empty VC that was ignored.
- clr_err  in  1  synchronous clear of all overflow/underflow bits.

## Operation
- Each VC has its own rd_ptr, wr_ptr and count. Pointers wrap explicitly: DEPTH−1 → 0. There is no reliance on power-of-two overflow.
- Status is derived from count only: empty = (count==0), full = (count==DEPTH), almost_full = (count ≥ DEPTH−AF_MARGIN).
- Push is accepted when !full[push_vc], or when a pop to the same VC is accepted in the same cycle.
  - An accepted push writes storage[push_vc][wr_ptr] and advances wr_ptr.
  - A rejected push leaves state unchanged and sets overflow[push_vc].
- Pop is accepted when !empty[pop_vc]: it advances rd_ptr. A pop of an empty VC is ignored and sets underflow[pop_vc].
- Count update per VC: +1 on push only, −1 on pop only, unchanged on both or neither.
- Push and pop to different VCs in the same cycle are fully independent.
- Same VC, empty, push+pop: the push is accepted and the pop is ignored (no bypass). underflow is set and count becomes 1.
- Same VC, full, push+pop: both are accepted. Count stays DEPTH and no overflow is flagged.
- push_vc or pop_vc ≥ NUM_VC: the request is ignored and no flag is set. A SIM_ONLY assertion fires.
- clr_err has priority over a same-cycle error set: the flags read 0 the next cycle.

## Timing
- Async reset: all pointers and counts go to 0, empty='1, full=0, almost_full=0 (or '1 when AF_MARGIN=DEPTH), overflow=0, underflow=0. Storage is not reset.
- Write-to-read latency is 1 cycle: data pushed on edge N is visible on pop_data from edge N (after the edge) when it is at the head.
- pop_data and pop_valid are combinational in pop_vc and registered state. They are valid in the same cycle as the pop request.
- All status outputs are registered-state functions. They reflect the result of the previous edge and have no combinational path from push/pop.
- Reset asserted mid-operation discards all queued entries immediately. The first cycle after release has every VC empty.

## Structure
- Package router_fifo_pkg holds:
  - the VC_W and CNT_W helper functions;
  - vc_status_t (empty, full, almost_full, overflow, underflow);
  - the SIM_ONLY assertion macros' message strings.
- Sub-module router_vc_lane: one VC's storage, pointers, count and flags, with inputs push_en/pop_en already decoded.
- Top-level decodes push_vc/pop_vc into one-hot enables, generates NUM_VC lanes, and muxes pop_data/pop_valid by pop_vc.

## Test plan
All scenarios use DATA_WIDTH=8, DEPTH=3, NUM_VC=4, AF_MARGIN=1.
- Reset, then idle 2 cycles → empty=4'b1111, full=0, count all 0, overflow=underflow=0.
- Push 0x11, 0x22, 0x33 to VC2 → count[2]=3, full[2]=1, almost_full[2] set after 2nd push. Then 4th push 0x44 → dropped, overflow[2]=1, and pops return 0x11, 0x22, 0x33.
- Wrap: on VC1, alternate push/pop 10 times with data 0..9 → pop_data matches 0..9 in order, and count[1] never exceeds 1.
- VC0 full, push 0x55 + pop on VC0 same cycle → pop returns head, count[0] stays 3, overflow[0]=0. Meanwhile push to VC3 in the same cycle lands independently.
- VC1 empty, push 0xAA + pop on VC1 → count[1]=1, underflow[1]=1, next cycle pop_data=0xAA. Then clr_err pulse → underflow cleared.
- rst_n low for 1 cycle with VC0/VC2 partially filled → all counts 0 immediately. After release, push 0x77 to VC0 → pop_data 0x77.
